// File: rtl/fast_window_if.sv
// Pixel stream in / 7x7 window out bundle for fast_window_buffer.
// master = pixel source and window consumer, slave = the buffer itself.
interface fast_window_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
);
    logic                                  pix_valid;
    logic                                  pix_sof;
    logic [DATA_WIDTH-1:0]                 pix_data;
    logic                                  window_valid;
    logic [0:6][0:6][DATA_WIDTH-1:0]       window;
    logic [$clog2(IMG_WIDTH)-1:0]          win_x;
    logic [$clog2(IMG_HEIGHT)-1:0]         win_y;
    logic                                  frame_err;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  window_valid, window, win_x, win_y, frame_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output window_valid, window, win_x, win_y, frame_err
    );
endinterface

// File: rtl/fast_window_buffer.sv
// 7x7 sliding window over a raster pixel stream using six line buffers.
// Optional framing checker enabled by defining FAST_WIN_FRAME_CHECK_EN.
module fast_window_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    fast_window_if.slave  bus
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    typedef enum logic [0:0] {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;
    typedef logic [0:6][0:6][DATA_WIDTH-1:0] win_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d, col_s;
    logic [YW-1:0]         y_q, y_d, row_s;
    logic [XW-1:0]         win_x_q, win_x_d;
    logic [YW-1:0]         win_y_q, win_y_d;
    logic                  win_valid_q, win_valid_d;
    win_t                  window_q, window_d;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] lb_mem [0:5][0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] lb_rd_s [0:5];

    // Pixel acceptance and the column/row it lands on (sof forces 0,0)
    always_comb begin
        accept_s = 1'b0;
        case (state_q)
            WAIT_SOF: accept_s = bus.pix_valid & bus.pix_sof;
            ACTIVE:   accept_s = bus.pix_valid;
            default:  accept_s = 1'b0;
        endcase
        if (bus.pix_sof) begin
            col_s = {XW{1'b0}};
            row_s = {YW{1'b0}};
        end else begin
            col_s = x_q;
            row_s = y_q;
        end
    end

    // Line-buffer read port, one column across all six lines
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            lb_rd_s[k] = lb_mem[k][col_s];
        end
    end

    // Line buffers shift the column down one line per accepted pixel
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_mem[0][col_s] <= bus.pix_data;
            for (int k = 0; k < 5; k++) begin
                lb_mem[k+1][col_s] <= lb_rd_s[k];
            end
        end
    end

    // Next-state: raster counters, window shift and window qualification
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        win_valid_d = 1'b0;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        window_d    = window_q;
        if (accept_s) begin
            for (int r = 0; r < 7; r++) begin
                for (int c = 0; c < 6; c++) begin
                    window_d[r][c] = window_q[r][c+1];
                end
            end
            window_d[0][6] = bus.pix_data;
            for (int r = 0; r < 6; r++) begin
                window_d[r+1][6] = lb_rd_s[r];
            end
            // Only windows fully inside the current frame's lines are valid
            if ((col_s >= XW'(6)) && (row_s >= YW'(6))) begin
                win_valid_d = 1'b1;
                win_x_d     = col_s - XW'(3);
                win_y_d     = row_s - YW'(3);
            end else begin
                win_valid_d = 1'b0;
            end
            if (col_s == XW'(IMG_WIDTH - 1)) begin
                x_d = {XW{1'b0}};
                if (row_s == YW'(IMG_HEIGHT - 1)) begin
                    y_d     = {YW{1'b0}};
                    state_d = WAIT_SOF;
                end else begin
                    y_d     = row_s + YW'(1);
                    state_d = ACTIVE;
                end
            end else begin
                x_d     = col_s + XW'(1);
                y_d     = row_s;
                state_d = ACTIVE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SOF;
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            win_valid_q <= 1'b0;
            win_x_q     <= {XW{1'b0}};
            win_y_q     <= {YW{1'b0}};
            window_q    <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_valid_q <= win_valid_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            window_q    <= window_d;
        end
    end

    assign bus.window_valid = win_valid_q;
    assign bus.window       = window_q;
    assign bus.win_x        = win_x_q;
    assign bus.win_y        = win_y_q;

`ifdef FAST_WIN_FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;

    // Sticky framing error: sof off-grid, or data while waiting for sof
    always_comb begin
        frame_err_d = frame_err_q;
        if (bus.pix_valid && bus.pix_sof && (state_q == ACTIVE) &&
            ((x_q != {XW{1'b0}}) || (y_q != {YW{1'b0}}))) begin
            frame_err_d = 1'b1;
        end else if (bus.pix_valid && !bus.pix_sof && (state_q == WAIT_SOF)) begin
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // Framing error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_fast_window_buffer.sv
// Randomized bench for fast_window_buffer on a 16x12 image; a frame-image
// model predicts every window from absolute pixel coordinates.
module tb_fast_window_buffer;
    localparam int DW = 8;
    localparam int W  = 16;
    localparam int H  = 12;
`ifdef FAST_WIN_FRAME_CHECK_EN
    localparam logic ERR_LIT = 1'b1;
`else
    localparam logic ERR_LIT = 1'b0;
`endif

    typedef logic [0:6][0:6][DW-1:0] win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fast_window_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    fast_window_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_win = 0;
    int cap_idx = 0;
    int cap_wx, cap_wy, cap_c, cap_06, cap_60;

    // Model: image of the frame in progress plus expected raster position
    logic [DW-1:0] img [0:H-1][0:W-1];
    int   mx = 0, my = 0;
    bit   m_active = 1'b0;
    bit   exp_valid = 1'b0;
    bit   exp_err = 1'b0;
    int   exp_wx = 0, exp_wy = 0;
    win_t exp_win = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string nm, input win_t act, input win_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_valid = 1'b0;
        if (!rst_n) begin
            mx = 0; my = 0; m_active = 1'b0;
            exp_err = 1'b0; exp_wx = 0; exp_wy = 0; exp_win = '0;
        end else if (bus.pix_valid && (bus.pix_sof || m_active)) begin
            if (bus.pix_sof) begin
`ifdef FAST_WIN_FRAME_CHECK_EN
                if (m_active && !(mx == 0 && my == 0)) exp_err = 1'b1;
`endif
                mx = 0; my = 0;
            end
            m_active = 1'b1;
            img[my][mx] = bus.pix_data;
            if (mx >= 6 && my >= 6) begin
                exp_valid = 1'b1;
                exp_wx = mx - 3;
                exp_wy = my - 3;
                for (int r = 0; r < 7; r++)
                    for (int c = 0; c < 7; c++)
                        exp_win[r][c] = img[my - r][mx - 6 + c];
            end
            mx++;
            if (mx == W) begin
                mx = 0; my++;
                if (my == H) begin my = 0; m_active = 1'b0; end
            end
        end else if (bus.pix_valid && !m_active) begin
`ifdef FAST_WIN_FRAME_CHECK_EN
            exp_err = 1'b1;
`endif
        end
    endtask

    // Single compare process: update model at the edge, check 1 time unit later
    always begin
        @(posedge clk);
        model_step();
        #1;
        chk("window_valid", 64'(bus.window_valid), 64'(exp_valid));
        chk("frame_err", 64'(bus.frame_err), 64'(exp_err));
        if (exp_valid) begin
            chk("win_x", 64'(bus.win_x), 64'(exp_wx));
            chk("win_y", 64'(bus.win_y), 64'(exp_wy));
            chk_win("window", bus.window, exp_win);
        end
        if (bus.window_valid === 1'b1) begin
            if (n_win == cap_idx) begin
                cap_wx = int'(bus.win_x);
                cap_wy = int'(bus.win_y);
                cap_c  = int'(bus.window[3][3]);
                cap_06 = int'(bus.window[0][6]);
                cap_60 = int'(bus.window[6][0]);
            end
            n_win++;
        end
    end

    task automatic drive(input bit v, input bit s, input logic [DW-1:0] d);
        @(negedge clk);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, DW'($urandom));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_sof = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends a frame in raster order, stopping before (stop_x, stop_y) if given
    task automatic send_frame(input int gap_pct, input int stop_x, input int stop_y, input bit rnd);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == stop_x && y == stop_y) return;
                while ($urandom_range(99) < gap_pct) idle(1);
                drive(1'b1, (x == 0 && y == 0), rnd ? DW'($urandom) : DW'((16 * y + x) & 255));
            end
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = '0;
        reset_dut();
        #1;
        chk_win("reset_window", bus.window, '0);
        chk("reset_win_x", 64'(bus.win_x), 64'd0);
        chk("reset_win_y", 64'(bus.win_y), 64'd0);
        chk("reset_valid", 64'(bus.window_valid), 64'd0);

        // Continuous frame with first-window pins
        n_win = 0; cap_idx = 0;
        send_frame(0, -1, -1, 1'b0);
        idle(4);
        chk("t1_count", 64'(n_win), 64'd60);
        chk("t1_first_x", 64'(cap_wx), 64'd3);
        chk("t1_first_y", 64'(cap_wy), 64'd3);
        chk("t1_center", 64'(cap_c), 64'd51);
        chk("t1_w06", 64'(cap_06), 64'd102);
        chk("t1_w60", 64'(cap_60), 64'd0);

        // Same frame with random gaps, then random pixel data with gaps
        n_win = 0;
        send_frame(30, -1, -1, 1'b0);
        idle(4);
        chk("t2_count", 64'(n_win), 64'd60);
        n_win = 0;
        send_frame(25, -1, -1, 1'b1);
        idle(4);
        chk("t2r_count", 64'(n_win), 64'd60);

        // Reset at pixel (5,8), leftover pixels without sof, then new frame
        reset_dut();
        send_frame(0, 5, 8, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.pix_valid = 1'b1; bus.pix_sof = 1'b0; bus.pix_data = 8'd133;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_win = 0;
        for (int x = 6; x < W; x++) drive(1'b1, 1'b0, DW'(128 + x));
        idle(2);
        chk("t3_ignored", 64'(n_win), 64'd0);
        chk("t3_err", 64'(bus.frame_err), 64'(ERR_LIT));
        send_frame(10, -1, -1, 1'b0);
        idle(4);
        chk("t3_count", 64'(n_win), 64'd60);

        // Mid-frame sof at (5,8) restarts the frame
        reset_dut();
        send_frame(0, 5, 8, 1'b0);
        n_win = 0;
        send_frame(0, -1, -1, 1'b0);
        idle(4);
        chk("t4_count", 64'(n_win), 64'd60);
        chk("t4_err", 64'(bus.frame_err), 64'(ERR_LIT));

        // Two back-to-back frames, sof right after the last pixel
        reset_dut();
        n_win = 0; cap_idx = 60;
        send_frame(0, -1, -1, 1'b0);
        send_frame(0, -1, -1, 1'b0);
        idle(4);
        chk("t6_count", 64'(n_win), 64'd120);
        chk("t6_first_x", 64'(cap_wx), 64'd3);
        chk("t6_first_y", 64'(cap_wy), 64'd3);
        chk("t6_center", 64'(cap_c), 64'd51);
        chk("t6_err", 64'(bus.frame_err), 64'd0);

        // Extra pixel after frame end without sof
        n_win = 0;
        drive(1'b1, 1'b0, 8'h55);
        idle(3);
        chk("t5_count", 64'(n_win), 64'd0);
        chk("t5_err", 64'(bus.frame_err), 64'(ERR_LIT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
